// File: rtl/uart_tx_fifo_if.sv
// +----------------------------------------------------------------------+
// | uart_tx_fifo_if: push port and status/serial lines of uart_tx_fifo    |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface uart_tx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  logic                     wr_en;
  logic [DATA_W-1:0]        wr_data;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     busy;
  logic                     tx;

  modport master (
    output wr_en, wr_data,
    input  full, empty, count, overflow, busy, tx
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, count, overflow, busy, tx
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// +----------------------------------------------------------------------+
// | uart_tx_fifo: FIFO-buffered UART transmitter, back-to-back framing    |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_tx_fifo #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_fifo_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BCW   = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W + 1);

  localparam logic [BCW-1:0]   BIT_LAST  = BCW'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                overflow_q, overflow_d;
  logic                busy_q, busy_d;
  logic                tx_q, tx_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   head;
  logic                push;
  logic                pop;
  logic                bit_last;

  always_comb begin
    push       = bus.wr_en && !full_q;
    head       = mem_q[rd_ptr_q];
    bit_last   = (bit_cnt_q == BIT_LAST);
    pop        = 1'b0;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;

    case (state_q)
      S_IDLE: begin
        if (!empty_q) pop = 1'b1;
      end
      S_START: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = '0;
            state_d   = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_PAR: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = S_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          if (bit_idx_q == STOP_LAST) begin
            bit_idx_d = '0;
            if (!empty_q) pop = 1'b1;
            else          state_d = S_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Parity is latched from the popped word so shifting cannot disturb it.
    if (pop) begin
      shift_d   = head;
      par_d     = (^head) ^ (PARITY == 2);
      bit_cnt_d = '0;
      bit_idx_d = '0;
      state_d   = S_START;
    end

    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    full_d     = (count_d == CNT_FULL);
    empty_d    = (count_d == '0);
    overflow_d = bus.wr_en && full_q;
    busy_d     = (state_d != S_IDLE);

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      S_PAR:   tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      tx_q       <= tx_d;
    end
  end

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = busy_q;
  assign bus.tx       = tx_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// +----------------------------------------------------------------------+
// | tb_uart_tx_fifo: directed scoreboard bench for uart_tx_fifo           |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_fifo;

  localparam int CLKS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en;
  logic [8:0] wr_data;
  int         sel;
  int         checks = 0;
  int         errors = 0;
  bit         exp_q[$];

  logic       tx_s, busy_s, empty_s, full_s, overflow_s;
  logic [2:0] count_s;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_W(8), .DEPTH(4)) bus0 ();
  uart_tx_fifo_if #(.DATA_W(8), .DEPTH(4)) bus1 ();
  uart_tx_fifo_if #(.DATA_W(8), .DEPTH(4)) bus2 ();
  uart_tx_fifo_if #(.DATA_W(7), .DEPTH(4)) bus3 ();

  assign bus0.wr_en   = wr_en && (sel == 0);
  assign bus1.wr_en   = wr_en && (sel == 1);
  assign bus2.wr_en   = wr_en && (sel == 2);
  assign bus3.wr_en   = wr_en && (sel == 3);
  assign bus0.wr_data = wr_data[7:0];
  assign bus1.wr_data = wr_data[7:0];
  assign bus2.wr_data = wr_data[7:0];
  assign bus3.wr_data = wr_data[6:0];

  uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(CLKS), .DEPTH(4), .PARITY(0), .STOP_BITS(1))
    u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(CLKS), .DEPTH(4), .PARITY(1), .STOP_BITS(1))
    u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(CLKS), .DEPTH(4), .PARITY(2), .STOP_BITS(1))
    u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  uart_tx_fifo #(.DATA_W(7), .CLKS_PER_BIT(CLKS), .DEPTH(4), .PARITY(2), .STOP_BITS(2))
    u3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  always_comb begin
    tx_s = bus0.tx; busy_s = bus0.busy; empty_s = bus0.empty;
    full_s = bus0.full; overflow_s = bus0.overflow; count_s = bus0.count;
    case (sel)
      1: begin
        tx_s = bus1.tx; busy_s = bus1.busy; empty_s = bus1.empty;
        full_s = bus1.full; overflow_s = bus1.overflow; count_s = bus1.count;
      end
      2: begin
        tx_s = bus2.tx; busy_s = bus2.busy; empty_s = bus2.empty;
        full_s = bus2.full; overflow_s = bus2.overflow; count_s = bus2.count;
      end
      3: begin
        tx_s = bus3.tx; busy_s = bus3.busy; empty_s = bus3.empty;
        full_s = bus3.full; overflow_s = bus3.overflow; count_s = bus3.count;
      end
      default: ;
    endcase
  end

  function automatic int dw_of(input int s);
    return (s == 3) ? 7 : 8;
  endfunction

  function automatic int par_of(input int s);
    return (s == 0) ? 0 : ((s == 1) ? 1 : 2);
  endfunction

  function automatic int stop_of(input int s);
    return (s == 3) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start, LSB-first data, optional parity, stop bits.
  task automatic push_exp(input logic [8:0] d);
    bit p;
    p = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < dw_of(sel); i++) begin
      exp_q.push_back(d[i]);
      p ^= d[i];
    end
    if (par_of(sel) == 2) p = ~p;
    if (par_of(sel) != 0) exp_q.push_back(p);
    for (int i = 0; i < stop_of(sel); i++) exp_q.push_back(1'b1);
  endtask

  task automatic push_word(input logic [8:0] d, input bit accept);
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
    if (accept) push_exp(d);
  endtask

  // Waits at most 'limit' cycles for the start bit, then expects every
  // queued bit for exactly CLKS cycles with no gaps, then idle.
  task automatic stream_check(input int limit);
    int  n;
    bit  b;
    bit  first;
    n = 0;
    while (tx_s !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("start_bit_latency", {31'd0, tx_s}, 32'd0);
    chk("busy_in_frame", {31'd0, busy_s}, 32'd1);
    first = 1'b1;
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      for (int c = 0; c < CLKS; c++) begin
        if (!first) @(negedge clk);
        first = 1'b0;
        chk("tx_bit", {31'd0, tx_s}, {31'd0, b});
      end
    end
    @(negedge clk);
    chk("busy_after_frame", {31'd0, busy_s}, 32'd0);
    chk("tx_idle_after_frame", {31'd0, tx_s}, 32'd1);
    chk("empty_after_frame", {31'd0, empty_s}, 32'd1);
  endtask

  initial begin
    sel     = 0;
    wr_en   = 1'b0;
    wr_data = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx_s}, 32'd1);
    chk("rst_busy", {31'd0, busy_s}, 32'd0);
    chk("rst_empty", {31'd0, empty_s}, 32'd1);
    chk("rst_full", {31'd0, full_s}, 32'd0);
    chk("rst_count", {29'd0, count_s}, 32'd0);
    chk("rst_overflow", {31'd0, overflow_s}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single 8N1 frame, one-cycle push-to-start latency.
    push_word(9'h0A5, 1'b1);
    chk("lat_tx_before_pop", {31'd0, tx_s}, 32'd1);
    chk("lat_count", {29'd0, count_s}, 32'd1);
    stream_check(1);

    // Parity variants and the 7-bit, 2-stop corner.
    sel = 1;
    push_word(9'h007, 1'b1);
    stream_check(1);
    sel = 2;
    push_word(9'h007, 1'b1);
    stream_check(1);
    sel = 3;
    push_word(9'h055, 1'b1);
    stream_check(1);

    // Overflow with the serialiser busy, then back-to-back drain.
    sel = 0;
    push_word(9'h00F, 1'b1);
    fork
      stream_check(1);
      begin
        for (int i = 0; i < 6; i++) begin
          push_word(9'h010 + 9'(i), i < 4);
          chk("ovf_count", {29'd0, count_s}, (i < 4) ? i + 1 : 4);
          chk("ovf_pulse", {31'd0, overflow_s}, (i < 4) ? 0 : 1);
          chk("ovf_full", {31'd0, full_s}, (i < 3) ? 0 : 1);
        end
        @(negedge clk);
        chk("ovf_pulse_end", {31'd0, overflow_s}, 32'd0);
      end
    join

    // Push coinciding with the STOP->START pop.
    push_word(9'h021, 1'b1);
    fork
      stream_check(1);
      begin
        push_word(9'h022, 1'b1);
        chk("pp_count_pre", {29'd0, count_s}, 32'd1);
        repeat (39) @(negedge clk);
        chk("pp_count_hold", {29'd0, count_s}, 32'd1);
        wr_data = 9'h023;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
        push_exp(9'h023);
        chk("pp_count_same", {29'd0, count_s}, 32'd1);
        chk("pp_no_overflow", {31'd0, overflow_s}, 32'd0);
        chk("pp_start_bit", {31'd0, tx_s}, 32'd0);
      end
    join

    // Asynchronous reset in the middle of a DATA bit.
    push_word(9'h099, 1'b0);
    push_word(9'h066, 1'b0);
    repeat (12) @(negedge clk);
    chk("mid_busy", {31'd0, busy_s}, 32'd1);
    chk("mid_count", {29'd0, count_s}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx", {31'd0, tx_s}, 32'd1);
    chk("arst_count", {29'd0, count_s}, 32'd0);
    chk("arst_empty", {31'd0, empty_s}, 32'd1);
    chk("arst_busy", {31'd0, busy_s}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_word(9'h03C, 1'b1);
    stream_check(1);
    repeat (8) @(negedge clk);
    chk("post_tx_idle", {31'd0, tx_s}, 32'd1);
    chk("post_busy", {31'd0, busy_s}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered UART transmitter that replaces the fixed single-byte serial path driving the CPU's `tx` pin. The CPU, or any bus master, pushes words into an internal FIFO. A framing state machine drains the FIFO and serialises each word onto `tx`. Data width, baud divisor, FIFO depth, parity mode and stop-bit count are all configurable, and back-to-back frames are sent without idle gaps.

## Interface
- `DATA_W`, 8: bits per character, 5..9.
- `CLKS_PER_BIT`, 868: clock cycles per bit (100 MHz / 115200), ≥2.
- `DEPTH`, 16: FIFO entries, power of two, ≥2.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  one clock; reset is asynchronous and active-low.
- `wr_en`  in  1  push request.
- `wr_data`  in  DATA_W  word to push.
- `full`  out  1  FIFO holds DEPTH entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  one-cycle pulse: push rejected.
- `busy`  out  1  serialiser not in IDLE.
- `tx`  out  1  serial line, idle high.

## Operation
- **Push acceptance**
  - A push is accepted when `wr_en` && !`full`, with `full` sampled before the edge.
  - A push while `full` is dropped and `overflow` pulses for 1 cycle. This holds even if a pop occurs in the same cycle.
- **Occupancy and pointers**
  - `count` is +1 on an accepted push, −1 on a pop, and unchanged when both occur in the same cycle.
  - `full` = (`count`==DEPTH); `empty` = (`count`==0).
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- **FSM states:** IDLE, START, DATA, PAR, STOP. A bit-cycle counter runs 0..CLKS_PER_BIT−1, and a bit index runs 0..DATA_W−1.
  - **IDLE:** `tx`=1. If !`empty`, pop the head into the shift register, clear the counters and go to START.
  - **START:** `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - **DATA:** `tx`=shift[0], LSB first. Shift after each bit. After DATA_W bits go to PAR if PARITY≠0, else STOP.
  - **PAR:** `tx` = XOR of the data bits for even parity, or its inverse for odd parity. Lasts CLKS_PER_BIT cycles, then go to STOP.
  - **STOP:** `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles.
    - On the last cycle, if !`empty`, pop and go directly to START (no idle bit).
    - Otherwise go to IDLE.
- Parity is computed from the word as popped, not from the shifted register.
- `busy` = (state≠IDLE).
- FIFO storage is not reset. Only the pointers, `count` and the FSM are reset.

## Timing
- **Reset values:** `tx`=1, `full`=0, `empty`=1, `count`=0, `overflow`=0, `busy`=0, FSM=IDLE, pointers=0.
- **Reset assertion:** asynchronous. `tx` goes high immediately, any frame in progress is aborted, and FIFO contents are discarded.
- **Reset deassertion:** takes effect at the next rising edge.
- **Push to start bit:** a push accepted at edge k into an empty, idle block makes `count`=1 after k. The pop at edge k+1 drives `tx`=0 and `busy`=1 after k+1. Latency from accepted push to start bit is 1 cycle.
- **Frame length:** (1 + DATA_W + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles exactly. Back-to-back frames have zero gap.
- **Outputs:** all registered. `tx` is glitch-free.
- **Overflow:** asserted in the cycle after the rejected `wr_en` edge, for exactly 1 cycle per rejected push.

## Test plan
- **Single frame:** DATA_W=8, CLKS_PER_BIT=4, PARITY=0, push 0xA5.
  - `tx` sequence is 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total).
  - `tx` falls 1 cycle after the push; `busy` drops after the stop bit.
- **Parity:** PARITY=1, push 0x07 → parity bit is 1. PARITY=2, push 0x07 → parity bit is 0. Frame length is 11×CLKS_PER_BIT.
- **Overflow and drain:** DEPTH=4, hold the serialiser busy, then push 6 words 0x10..0x15.
  - `count` saturates at 4 with `full`=1.
  - `overflow` pulses for each rejected push.
  - The accepted words are transmitted back-to-back in order with no idle high between frames; `empty`=1 at the end.
- **Simultaneous push/pop:** with `count`=1 at a STOP→START transition, push in the same cycle as the pop → `count` stays 1 and no `overflow`.
- **Reset mid-frame:** assert `rst_n`=0 during DATA.
  - `tx`=1 immediately; `count`=0, `empty`=1, `busy`=0.
  - After release, push 0x3C → clean full frame.
- **Config corner:** DATA_W=7, STOP_BITS=2, PARITY=2, push 0x55 → 7 data bits, parity bit 1, 2 stop bits, 11×CLKS_PER_BIT cycles.
